output_port: RTL and testbench

Per-direction output stage of the 5-port NoC router: the transmit side facing a neighbour's input queue. It arbitrates round-robin among the input queues requesting this direction, holds a wormhole lock from head flit to tail flit, and drives one registered 16-bit flit per cycle onto the link. Credit-based flow control against the downstream queue guarantees no flit is sent without buffer space. One instance sits behind each of north_o, south_o, east_o, west_o and local_o.

---
 rtl/output_port.sv | 164 ++++++++++++++++
 tb/tb_output_port.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/output_port.sv
// output_port: transmit stage of one router direction.
// Round-robin arbitration among input queues, wormhole lock from head to tail,
// credit-based flow control toward the downstream input queue, registered flit output.
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst       synchronous active-low reset
//   req_i     per-queue request: head flit of queue i is routed here
//   flit_i    head flits of all queues, queue i in bits [16*i+15:16*i]
//   pop_o     combinational one-hot (or zero) dequeue strobe
//   credit_i  one-cycle pulse, downstream freed one slot
//   flit_o    registered outgoing flit (holds last value when idle)
//   valid_o   registered, flit_o carries a new flit this cycle
//   err_o     sticky protocol error, cleared only by reset
module output_port #(
    parameter int unsigned NUM_IN    = 4,
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_IN-1:0]      req_i,
    input  logic [16*NUM_IN-1:0]   flit_i,
    output logic [NUM_IN-1:0]      pop_o,
    input  logic                   credit_i,
    output logic [15:0]            flit_o,
    output logic                   valid_o,
    output logic                   err_o
);

    localparam int unsigned IdxW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int unsigned CrW  = $clog2(BUF_DEPTH + 1);
    localparam logic [CrW-1:0] CrMax = CrW'(BUF_DEPTH);

    typedef enum logic {StIdle, StLocked} state_e;

    state_e          r_state, w_state_next;
    logic [IdxW-1:0] r_owner, w_owner_next;
    logic [IdxW-1:0] r_rr, w_rr_next;
    logic [CrW-1:0]  r_credits, w_credits_next;
    logic [15:0]     r_flit;
    logic            r_valid;
    logic            r_err, w_err_next;

    logic [15:0]     w_flits [NUM_IN];
    logic            w_pop_any;
    logic [IdxW-1:0] w_sel;
    logic [IdxW-1:0] w_cand;
    logic [15:0]     w_sel_flit;
    logic [1:0]      w_sel_type;
    logic            w_bad_req;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
        assign w_flits[g] = flit_i[16*g +: 16];
    end

    function automatic logic [IdxW-1:0] rr_idx(input logic [IdxW-1:0] base,
                                               input int unsigned k);
        int unsigned s;
        s = (32'(base) + k) % NUM_IN;
        return IdxW'(s);
    endfunction

    function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] idx);
        if (32'(idx) == NUM_IN - 1) return '0;
        return idx + IdxW'(1);
    endfunction

    // Output process: grant selection and dequeue strobe.
    // Bit 14 of the flit type is set exactly for head (01) and single (11).
    always_comb begin
        w_pop_any = 1'b0;
        w_sel     = r_owner;
        w_cand    = '0;
        w_bad_req = 1'b0;
        pop_o     = '0;
        if (r_state == StIdle) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (req_i[i] && !w_flits[i][14]) w_bad_req = 1'b1;
            end
            for (int unsigned k = 0; k < NUM_IN; k++) begin
                w_cand = rr_idx(r_rr, k);
                if (!w_pop_any && req_i[w_cand] && w_flits[w_cand][14]) begin
                    w_pop_any = 1'b1;
                    w_sel     = w_cand;
                end
            end
        end else begin
            w_pop_any = req_i[r_owner];
        end
        // No credit or reset in progress: nothing leaves.
        if (!rst || r_credits == '0) w_pop_any = 1'b0;
        if (w_pop_any) pop_o[w_sel] = 1'b1;
        w_sel_flit = w_flits[w_sel];
        w_sel_type = w_sel_flit[15:14];
    end

    // Next-state process.
    always_comb begin
        w_state_next   = r_state;
        w_owner_next   = r_owner;
        w_rr_next      = r_rr;
        w_err_next     = r_err;
        w_credits_next = r_credits;
        case (r_state)
            StIdle: begin
                if (w_bad_req) w_err_next = 1'b1;
                if (w_pop_any) begin
                    if (w_sel_type == 2'b01) begin
                        w_state_next = StLocked;
                        w_owner_next = w_sel;
                    end else begin
                        w_rr_next = wrap_inc(w_sel);
                    end
                end
            end
            StLocked: begin
                if (w_pop_any) begin
                    if (w_sel_type == 2'b10) begin
                        w_state_next = StIdle;
                        w_rr_next    = wrap_inc(r_owner);
                    end else if (w_sel_type[0]) begin
                        // Head or single inside a packet: forwarded, but flagged.
                        w_err_next = 1'b1;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
        case ({w_pop_any, credit_i})
            2'b10: w_credits_next = r_credits - CrW'(1);
            2'b01: begin
                if (r_credits == CrMax) w_err_next = 1'b1;
                else w_credits_next = r_credits + CrW'(1);
            end
            default: w_credits_next = r_credits;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= StIdle;
            r_owner   <= '0;
            r_rr      <= '0;
            r_credits <= CrMax;
            r_flit    <= 16'h0000;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_owner   <= w_owner_next;
            r_rr      <= w_rr_next;
            r_credits <= w_credits_next;
            r_err     <= w_err_next;
            r_valid   <= w_pop_any;
            if (w_pop_any) r_flit <= w_sel_flit;
        end
    end

    assign flit_o  = r_flit;
    assign valid_o = r_valid;
    assign err_o   = r_err;

endmodule

// File: tb/tb_output_port.sv
module tb_output_port;

    localparam int NUM_IN = 4;
    localparam int BUF    = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NUM_IN-1:0]    req_i = '0;
    logic [16*NUM_IN-1:0] flit_i = '0;
    logic [NUM_IN-1:0]    pop_o;
    logic                 credit_i = 1'b0;
    logic [15:0]          flit_o;
    logic                 valid_o;
    logic                 err_o;

    output_port #(.NUM_IN(NUM_IN), .BUF_DEPTH(BUF)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_i),
        .flit_i   (flit_i),
        .pop_o    (pop_o),
        .credit_i (credit_i),
        .flit_o   (flit_o),
        .valid_o  (valid_o),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] qin [NUM_IN][$];   // input queues feeding the port
    logic [15:0] sb [$];            // expected outgoing flits, in order

    // Reference state (committed) and next values (pending).
    bit m_locked = 0, p_locked = 0;
    int m_owner = 0, p_owner = 0;
    int m_rr = 0, p_rr = 0;
    int m_credits = BUF, p_credits = BUF;
    bit m_err = 0, p_err = 0;
    logic [15:0] m_last = '0, p_last = '0;
    int p_pop = -1;
    bit mon_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] ftype(input int i);
        logic [15:0] f;
        f = qin[i][0];
        return f[15:14];
    endfunction

    // One clock cycle: commit previous decision, drive inputs, predict, check pop_o.
    // mode: 0 no credit, 1 random credit, 2 forced credit, 3 credit whenever not full.
    task automatic step(input bit r, input int mode, input logic [NUM_IN-1:0] flush = '0);
        bit c;
        logic [NUM_IN-1:0] exp_pop;
        int t;
        @(posedge clk);
        #1;
        m_locked = p_locked; m_owner = p_owner; m_rr = p_rr;
        m_credits = p_credits; m_err = p_err; m_last = p_last;
        if (p_pop >= 0) void'(qin[p_pop].pop_front());
        for (int i = 0; i < NUM_IN; i++) if (flush[i]) qin[i].delete();
        case (mode)
            0: c = 0;
            1: c = (m_credits < BUF) && ($urandom_range(0, 1) == 1);
            2: c = 1;
            default: c = (m_credits < BUF);
        endcase
        rst = r;
        credit_i = c;
        for (int i = 0; i < NUM_IN; i++) begin
            req_i[i] = (qin[i].size() > 0);
            flit_i[16*i +: 16] = (qin[i].size() > 0) ? qin[i][0] : 16'h0000;
        end
        #1;
        p_pop = -1;
        p_locked = m_locked; p_owner = m_owner; p_rr = m_rr;
        p_credits = m_credits; p_err = m_err; p_last = m_last;
        if (!r) begin
            p_locked = 0; p_owner = 0; p_rr = 0; p_credits = BUF; p_err = 0; p_last = '0;
        end else begin
            if (!m_locked) begin
                for (int i = 0; i < NUM_IN; i++)
                    if (qin[i].size() > 0 && (ftype(i) == 2'b00 || ftype(i) == 2'b10)) p_err = 1;
                if (m_credits > 0) begin
                    for (int k = 0; k < NUM_IN; k++) begin
                        t = (m_rr + k) % NUM_IN;
                        if (p_pop < 0 && qin[t].size() > 0 &&
                            (ftype(t) == 2'b01 || ftype(t) == 2'b11)) p_pop = t;
                    end
                end
                if (p_pop >= 0) begin
                    if (ftype(p_pop) == 2'b01) begin
                        p_locked = 1;
                        p_owner = p_pop;
                    end else begin
                        p_rr = (p_pop + 1) % NUM_IN;
                    end
                end
            end else if (qin[m_owner].size() > 0 && m_credits > 0) begin
                p_pop = m_owner;
                if (ftype(m_owner) == 2'b10) begin
                    p_locked = 0;
                    p_rr = (m_owner + 1) % NUM_IN;
                end else if (ftype(m_owner) != 2'b00) begin
                    p_err = 1;
                end
            end
            if (p_pop >= 0) begin
                sb.push_back(qin[p_pop][0]);
                p_last = qin[p_pop][0];
                p_credits--;
            end
            if (c) begin
                if (p_pop < 0 && m_credits == BUF) p_err = 1;
                else p_credits++;
            end
        end
        exp_pop = (p_pop >= 0) ? NUM_IN'(1 << p_pop) : '0;
        check("pop_o", 32'(pop_o), 32'(exp_pop));
    endtask

    task automatic add_packet(input int i, input int nbody, input bit single);
        if (single) begin
            qin[i].push_back({2'b11, 14'($urandom)});
        end else begin
            qin[i].push_back({2'b01, 14'($urandom)});
            for (int b = 0; b < nbody; b++) qin[i].push_back({2'b00, 14'($urandom)});
            qin[i].push_back({2'b10, 14'($urandom)});
        end
    endtask

    task automatic refill();
        for (int n = 0; n < 40 && m_credits < BUF; n++) step(1, 3);
    endtask

    // Monitor: consumes an expected flit each time the DUT presents one.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (mon_en) begin
                if (valid_o) begin
                    if (sb.size() == 0) check("valid_o_unexpected", 32'(valid_o), 32'd0);
                    else check("flit_o", 32'(flit_o), 32'(sb.pop_front()));
                end
                check("flit_o_hold", 32'(flit_o), 32'(m_last));
                check("err_o", 32'(err_o), 32'(m_err));
            end
        end
    end

    initial begin
        step(0, 0);
        step(0, 0);
        mon_en = 1;

        // Two singles: 0 then 2; rr lands at 3, so 3 beats 0 next.
        qin[0].push_back(16'hC001);
        qin[2].push_back(16'hC002);
        for (int n = 0; n < 3; n++) step(1, 3);
        qin[0].push_back(16'hC010);
        qin[3].push_back(16'hC013);
        for (int n = 0; n < 4; n++) step(1, 3);

        // Wormhole lock on input 1 while input 3 waits with a head.
        qin[1].push_back(16'h4011); qin[1].push_back(16'h0022); qin[1].push_back(16'h8033);
        qin[3].push_back(16'h4044); qin[3].push_back(16'h8045);
        for (int n = 0; n < 8; n++) step(1, 3);

        // Credit exhaustion: 4 flits, stall, one credit releases one more.
        refill();
        add_packet(0, 4, 0);
        for (int n = 0; n < 7; n++) step(1, 0);
        step(1, 2);
        for (int n = 0; n < 3; n++) step(1, 0);
        for (int n = 0; n < 6; n++) step(1, 3);

        // Credit and pop together at credits==1 keeps streaming.
        refill();
        add_packet(1, 8, 0);
        for (int n = 0; n < 3; n++) step(1, 0);
        for (int n = 0; n < 4; n++) step(1, 2);
        for (int n = 0; n < 10; n++) step(1, 3);

        // Body at queue head while idle: never granted, err sticks.
        refill();
        qin[2].push_back(16'h0055);
        for (int n = 0; n < 3; n++) step(1, 3);
        step(1, 3, 4'b0100);
        step(1, 3);
        step(0, 0);
        refill();
        step(1, 0);
        // Extra credit while full.
        step(1, 2);
        step(1, 0);
        step(1, 0);
        step(0, 0);

        // Reset mid-packet abandons the lock; input 3 wins right after.
        qin[1].push_back(16'h4101); qin[1].push_back(16'h0102); qin[1].push_back(16'h8103);
        qin[3].push_back(16'h4301); qin[3].push_back(16'h8302);
        step(1, 3);
        step(1, 3);
        step(0, 0, 4'b0010);
        for (int n = 0; n < 5; n++) step(1, 3);

        // Randomised traffic with random credit return.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NUM_IN; i++)
                if (qin[i].size() == 0 && $urandom_range(0, 3) == 0)
                    add_packet(i, $urandom_range(0, 3), $urandom_range(0, 2) == 0);
            step(1, 1);
        end
        for (int n = 0; n < 80; n++) step(1, 3);
        step(1, 3);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
